cpu_debug_jtag_scan_master: RTL and testbench

- Clock-domain JTAG scan initiator that drives the virtual-JTAG signal set consumed by the CPU debug slave: tck, tdi, ir_in, cdr, sdr, udr, uir and rti. It samples tdo on the return path.
- Per command: loads a 2-bit IR, then one capture/shift/update DR scan of 38 bits. Returns the 38 bits captured from tdo.
- Serves as the on-chip debug-command source and as the simulation driver for the debug slave, whose JTAG inputs are otherwise tied off.

---
 rtl/cpu_debug_jtag_scan_master.sv | 163 ++++++++++++++++
 tb/tb_cpu_debug_jtag_scan_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_jtag_scan_master.sv
// cpu_debug_jtag_scan_master
// Clock-domain virtual-JTAG initiator for the CPU debug slave. Each command
// loads the virtual IR (UIR), then runs one capture/shift/update DR scan of
// DR_WIDTH bits and returns the bits captured from tdo.
// Optional: define CPU_DEBUG_SCAN_IR_CACHE_EN to skip the UIR phase when the
// requested IR matches the last one loaded since reset.
module cpu_debug_jtag_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  // cnt counts clk cycles inside one tck period; bit counts rising tck edges in SHIFT
  localparam int CW = $clog2(2*TCK_DIV);
  localparam int BW = $clog2(DR_WIDTH+1);
  localparam logic [CW-1:0] PER_LAST = CW'(2*TCK_DIV-1);
  localparam logic [CW-1:0] RISE_PRE = CW'(TCK_DIV-1);
  localparam logic [CW-1:0] HALF     = CW'(TCK_DIV);
  localparam logic [BW-1:0] BITS     = BW'(DR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                tck_q, tck_d;
  logic                tdi_q;
  logic [DR_WIDTH-1:0] sr_q;
  logic [DR_WIDTH-1:0] rsp_dr_q;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic                accept;
  logic                ir_hit;
  logic                shift_rise;

  assign accept     = (state_q == S_IDLE) && cmd_valid;
  assign shift_rise = (state_q == S_SHIFT) && (cnt_q == RISE_PRE);

`ifdef CPU_DEBUG_SCAN_IR_CACHE_EN
  // ir_in_q doubles as the cached IR; this bit says whether it is trustworthy
  logic cache_vld_q;
  assign ir_hit = cache_vld_q && (cmd_ir == ir_in_q);

  // cache becomes valid on the first IR load and is cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cache_vld_q <= 1'b0;
    else if (accept) cache_vld_q <= 1'b1;
  end
`else
  assign ir_hit = 1'b0;
`endif

  // next-state, period counter and shift bit counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tck_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (accept) state_d = ir_hit ? S_CDR : S_UIR;
      end
      S_UIR, S_CDR, S_UDR: begin
        if (cnt_q == PER_LAST) begin
          cnt_d = '0;
          case (state_q)
            S_UIR:   state_d = S_CDR;
            S_CDR:   state_d = S_SHIFT;
            default: state_d = S_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == RISE_PRE) bit_d = bit_q + 1'b1;
        if (cnt_q == PER_LAST) begin
          cnt_d = '0;
          if (bit_q == BITS) state_d = S_UDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // tck is registered so it never glitches; high in the second half of each active period
    if (state_d inside {S_UIR, S_CDR, S_SHIFT, S_UDR})
      tck_d = (cnt_d >= HALF);
  end

  // state, counters and tck register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tck_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tck_q   <= tck_d;
    end
  end

  // command capture, DR shift register, tdi launch and response capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q     <= '0;
      tdi_q    <= 1'b0;
      ir_in_q  <= '0;
      rsp_dr_q <= '0;
    end else begin
      if (accept) begin
        sr_q <= cmd_dr;
        if (!ir_hit) ir_in_q <= cmd_ir;
      end else if (shift_rise) begin
        sr_q <= {vji_tdo, sr_q[DR_WIDTH-1:1]};
      end
      // tdi changes only as tck goes low, so it is stable across the rising edge
      if (state_d != S_SHIFT)  tdi_q <= 1'b0;
      else if (cnt_d == '0)    tdi_q <= sr_q[0];
      if (state_d == S_DONE)   rsp_dr_q <= sr_q;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign vji_rti   = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_dr    = rsp_dr_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_in_q;
  assign vji_uir   = (state_q == S_UIR);
  assign vji_cdr   = (state_q == S_CDR);
  assign vji_sdr   = (state_q == S_SHIFT);
  assign vji_udr   = (state_q == S_UDR);

endmodule

// File: tb/tb_cpu_debug_jtag_scan_master.sv
// Scoreboard bench for cpu_debug_jtag_scan_master: stimulus pushes expected
// responses, a negedge monitor tracks the JTAG protocol and checks each response.
module tb_cpu_debug_jtag_scan_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_dr;
  logic        rsp_valid, busy;
  logic [37:0] rsp_dr;
  logic        vji_tck, vji_tdi, vji_tdo;
  logic [1:0]  vji_ir_in;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [1:0]  tdo_sel;   // 0: tie 0, 1: tie 1, 2: loopback

  assign vji_tdo = (tdo_sel == 2'd2) ? vji_tdi : tdo_sel[0];

  cpu_debug_jtag_scan_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .busy(busy),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
    .vji_rti(vji_rti)
  );

  always #5 clk = ~clk;

`ifdef CPU_DEBUG_SCAN_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct {
    logic [37:0] rsp;
    logic [37:0] din;
    logic [1:0]  ir;
    int          lat;
    int          uirn;
  } exp_t;

  exp_t exp_q[$];
  int   acc_hist[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   m_vld = 1'b0;
  logic [1:0] m_ir = 2'b00;
  int   last_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ctrl"}, {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr,
                        vji_rti, cmd_ready, busy, rsp_valid}, 64'b0000_0000_1100);
    chk({nm, "_rsp_dr"}, rsp_dr, 64'd0);
  endtask

  // ---------------- monitor ----------------
  int n_uir, n_cdr, n_sdr, n_udr, n_rise, n_ovl, tdi_bad, last_acc;
  int f_uir, f_cdr, f_sdr, f_udr;
  logic [37:0] tdi_bits;
  logic prev_tck = 1'b0, prev_tdi = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      n_rise = 0;
      prev_tck = 1'b0;
      prev_tdi = 1'b0;
      if (rsp_valid) begin
        checks++; errors++;
        $display("FAIL rsp_in_reset: got rsp_valid=1 expected 0");
      end
    end else begin
      if (cmd_valid && cmd_ready) begin
        last_acc = cyc;
        acc_hist.push_back(cyc);
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rise = 0; n_ovl = 0; tdi_bad = 0;
        f_uir = 0; f_cdr = 0; f_sdr = 0; f_udr = 0;
        tdi_bits = '0;
      end
      if (vji_uir) begin if (n_uir == 0) f_uir = cyc; n_uir++; end
      if (vji_cdr) begin if (n_cdr == 0) f_cdr = cyc; n_cdr++; end
      if (vji_sdr) begin if (n_sdr == 0) f_sdr = cyc; n_sdr++; end
      if (vji_udr) begin if (n_udr == 0) f_udr = cyc; n_udr++; end
      if ((int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr)) > 1) n_ovl++;
      if (vji_tck && !prev_tck && vji_sdr) begin
        if (n_rise < 38) tdi_bits[n_rise] = vji_tdi;
        if (vji_tdi !== prev_tdi) tdi_bad++;
        n_rise++;
      end
      prev_tck = vji_tck;
      prev_tdi = vji_tdi;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 rsp_dr=%0h expected no response", rsp_dr);
        end else begin
          exp_t e;
          bit ordered;
          e = exp_q.pop_front();
          ordered = (f_cdr < f_sdr) && (f_sdr < f_udr) && (e.uirn == 0 || f_uir < f_cdr);
          chk("rsp_dr", rsp_dr, e.rsp);
          chk("rsp_latency", cyc - last_acc, e.lat);
          chk("ir_in", vji_ir_in, e.ir);
          chk("uir_cycles", n_uir, e.uirn);
          chk("cdr_cycles", n_cdr, 4);
          chk("sdr_cycles", n_sdr, 152);
          chk("udr_cycles", n_udr, 4);
          chk("sdr_tck_rises", n_rise, 38);
          chk("tdi_bits", tdi_bits, e.din);
          chk("tdi_stable", tdi_bad, 0);
          chk("flag_overlap", n_ovl, 0);
          chk("flag_order", ordered, 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] ir, input logic [37:0] dr,
                       input logic [37:0] rsp, input bit push, input bit hold);
    exp_t e;
    bit hit;
    int t;
    hit = CACHE && m_vld && (ir == m_ir);
    if (!hit) begin m_vld = 1'b1; m_ir = ir; end
    e.rsp = rsp; e.din = dr; e.ir = ir;
    e.lat = hit ? 161 : 165;
    e.uirn = hit ? 0 : 4;
    last_lat = e.lat;
    if (push) exp_q.push_back(e);
    cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready && t < 1000);
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 1000 cycles");
    end
    @(posedge clk); #1;
    cmd_dr = ~dr; cmd_ir = ~ir;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(posedge clk); t++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    m_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_dr = '0; tdo_sel = 2'd2;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset_hold");
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // loopback
    issue(2'b10, 38'h2A_5A5A_C3C3, 38'h2A_5A5A_C3C3, 1, 0);
    wait_done();

    // tdo tied high / low
    tdo_sel = 2'd1;
    issue(2'b10, 38'h0, 38'h3F_FFFF_FFFF, 1, 0);
    wait_done();
    tdo_sel = 2'd0;
    issue(2'b10, 38'h15_5555_AAAA, 38'h0, 1, 0);
    wait_done();
    tdo_sel = 2'd2;

    // back-to-back with cmd_valid held; second command waits while busy
    acc_hist.delete();
    issue(2'b01, 38'h01_2345_6789, 38'h01_2345_6789, 1, 1);
    begin
      int gap;
      gap = last_lat + 1;
      issue(2'b11, 38'h3F_0000_FFFF, 38'h3F_0000_FFFF, 1, 0);
      wait_done();
      if (acc_hist.size() == 2) chk("accept_gap", acc_hist[1] - acc_hist[0], gap);
      else chk("accept_count", acc_hist.size(), 2);
    end

    // async reset mid-SHIFT, no response may follow
    issue(2'b10, 38'h2A_AAAA_5555, 38'h0, 0, 0);
    begin
      int t = 0;
      while (n_rise < 21 && t < 500) begin @(posedge clk); t++; end
      chk("reached_shift_bit20", n_rise >= 21, 1);
    end
    @(posedge clk); #2 reset_n = 1'b0;
    m_vld = 1'b0;
    #1 chk_reset("reset_async");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    issue(2'b01, 38'h1, 38'h1, 1, 0);
    wait_done();

    // IR cache sequence (model predicts skip only when the cache build is used)
    issue(2'b01, 38'h0F_F00F_F00F, 38'h0F_F00F_F00F, 1, 0);
    wait_done();
    issue(2'b11, 38'h30_0C03_00C0, 38'h30_0C03_00C0, 1, 0);
    wait_done();
    pulse_reset();
    @(posedge clk); #1;
    issue(2'b01, 38'h11, 38'h11, 1, 0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
